// File: rtl/datapath_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/WRITEBACK control of
// pc, ir and the register-bank write strobe, with fetch timeout and halt handling.
module datapath_sequencer #(
  parameter int                      ADDRESS_SIZE  = 32,
  parameter logic [ADDRESS_SIZE-1:0] BOOT_ADDRESS  = ADDRESS_SIZE'(32'h1000),
  parameter int                      FETCH_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    imem_req,
  input  logic                    imem_ready,
  input  logic [ADDRESS_SIZE-1:0] imem_instruction,
  output logic [ADDRESS_SIZE-1:0] pc,
  output logic [ADDRESS_SIZE-1:0] ir,
  input  logic                    dec_halt,
  input  logic                    dec_illegal,
  input  logic                    dec_register_write,
  input  logic                    branch_taken,
  input  logic [ADDRESS_SIZE-1:0] branch_target,
  output logic                    register_write_en,
  output logic                    busy,
  output logic                    halted,
  output logic                    error,
  output logic [31:0]             retired
);

  localparam int CNT_W = $clog2(FETCH_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDRESS_SIZE-1:0] pc_q, pc_d, ir_q, ir_d, tgt_q, tgt_d;
  logic [31:0]             ret_q, ret_d;
  logic [CNT_W-1:0]        wait_q, wait_d;
  logic                    bt_q, bt_d, err_q, err_d, rwe_d;
  logic                    req_q, busy_q, halted_q, rwe_q;

  // Next-state and datapath load decisions.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ret_d   = ret_q;
    wait_d  = wait_q;
    bt_d    = bt_q;
    tgt_d   = tgt_q;
    err_d   = err_q;
    rwe_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
        else       state_d = S_IDLE;
      end
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_instruction;
          wait_d  = '0;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d  = wait_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else if (dec_halt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        // A misaligned taken branch aborts before WRITEBACK, so pc/retired never move.
        bt_d  = branch_taken;
        tgt_d = branch_target;
        if (branch_taken && (branch_target[1:0] != 2'b00)) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          rwe_d   = dec_register_write;
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        if (bt_q) pc_d = tgt_q;
        else      pc_d = pc_q + ADDRESS_SIZE'(4);
        ret_d   = ret_q + 32'd1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and status registers; status decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= BOOT_ADDRESS;
      ir_q     <= '0;
      ret_q    <= 32'd0;
      wait_q   <= '0;
      bt_q     <= 1'b0;
      tgt_q    <= '0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      rwe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ret_q    <= ret_d;
      wait_q   <= wait_d;
      bt_q     <= bt_d;
      tgt_q    <= tgt_d;
      err_q    <= err_d;
      req_q    <= (state_d == S_FETCH);
      busy_q   <= (state_d == S_FETCH) || (state_d == S_DECODE) ||
                  (state_d == S_EXECUTE) || (state_d == S_WRITEBACK);
      halted_q <= (state_d == S_HALT);
      rwe_q    <= rwe_d;
    end
  end

  assign imem_req          = req_q;
  assign pc                = pc_q;
  assign ir                = ir_q;
  assign retired           = ret_q;
  assign register_write_en = rwe_q;
  assign busy              = busy_q;
  assign halted            = halted_q;
  assign error             = err_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: per-cycle reference model plus
// directed scenarios with hand-computed expectations.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        imem_req;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_instruction = 32'd0;
  logic [31:0] pc, ir;
  logic        dec_halt = 1'b0, dec_illegal = 1'b0, dec_register_write = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        register_write_en, busy, halted, error;
  logic [31:0] retired;

  int vectors = 0;
  int miscompares = 0;

  datapath_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .imem_req(imem_req),
    .imem_ready(imem_ready), .imem_instruction(imem_instruction),
    .pc(pc), .ir(ir), .dec_halt(dec_halt), .dec_illegal(dec_illegal),
    .dec_register_write(dec_register_write), .branch_taken(branch_taken),
    .branch_target(branch_target), .register_write_en(register_write_en),
    .busy(busy), .halted(halted), .error(error), .retired(retired)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 fetch, 2 decode, 3 execute, 4 writeback, 5 halt.
  int          m_phase;
  int          m_waited;
  logic [31:0] m_pc, m_ir, m_ret, m_tgt;
  logic        m_bt, m_rw, m_err;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= 0; m_waited <= 0; m_pc <= 32'h1000; m_ir <= 32'd0;
      m_ret <= 32'd0; m_tgt <= 32'd0; m_bt <= 1'b0; m_rw <= 1'b0; m_err <= 1'b0;
    end else begin
      if (m_phase == 0 && start) m_phase <= 1;
      if (m_phase == 1) begin
        if (imem_ready) begin
          m_ir <= imem_instruction; m_phase <= 2; m_waited <= 0;
        end else if (m_waited + 1 >= 16) begin
          m_phase <= 5; m_err <= 1'b1; m_waited <= 0;
        end else begin
          m_waited <= m_waited + 1;
        end
      end
      if (m_phase == 2) begin
        if (dec_illegal || dec_halt) begin
          m_phase <= 5; m_err <= dec_illegal;
        end else begin
          m_phase <= 3;
        end
      end
      if (m_phase == 3) begin
        m_bt <= branch_taken; m_tgt <= branch_target; m_rw <= dec_register_write;
        if (branch_taken && (branch_target % 4) != 0) begin
          m_phase <= 5; m_err <= 1'b1;
        end else begin
          m_phase <= 4;
        end
      end
      if (m_phase == 4) begin
        m_pc  <= m_bt ? m_tgt : m_pc + 32'd4;
        m_ret <= m_ret + 32'd1;
        m_phase <= 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_phase == 1});
    chk("busy", {31'd0, busy}, {31'd0, m_phase >= 1 && m_phase <= 4});
    chk("halted", {31'd0, halted}, {31'd0, m_phase == 5});
    chk("error", {31'd0, error}, {31'd0, m_err});
    chk("wr_en", {31'd0, register_write_en}, {31'd0, m_phase == 4 && m_rw});
    chk("pc", pc, m_pc);
    chk("ir", ir, m_ir);
    chk("retired", retired, m_ret);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go_reset();
    reset = 1'b0; start = 1'b0; imem_ready = 1'b1; dec_halt = 1'b0;
    dec_illegal = 1'b0; dec_register_write = 1'b1; branch_taken = 1'b0;
    branch_target = 32'd0;
    cyc(2);
    reset = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  logic [15:0] pulses;
  int          n;

  initial begin
    // Reset values
    cyc(1);
    chk("rst_pc", pc, 32'h1000);
    chk("rst_ir", ir, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    go_reset();
    cyc(3);
    chk("idle_wait_req", {31'd0, imem_req}, 32'd0);

    // Three sequential instructions, write pulses in cycles 4, 8, 12
    pulses = 16'd0;
    do_start();
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) cyc(1);
      imem_instruction = 32'hA000_0000 + 32'(k);
      pulses[k] = register_write_en;
    end
    imem_ready = 1'b0;
    chk("wr_pulses", {16'd0, pulses}, 32'h0000_1110);
    cyc(1);
    chk("seq_pc", pc, 32'h100C);
    chk("seq_retired", retired, 32'd3);
    chk("seq_ir", ir, 32'hA000_0009);

    // Fetch timeout: 16 FETCH cycles then HALT with error
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      if (halted) begin n = k; break; end
    end
    chk("timeout_cycles", 32'(n), 32'd16);
    chk("timeout_err", {31'd0, error}, 32'd1);
    chk("timeout_req", {31'd0, imem_req}, 32'd0);

    // Aligned branch then misaligned branch
    go_reset();
    branch_taken = 1'b1; branch_target = 32'h2000;
    do_start();
    cyc(4);
    chk("br_pc", pc, 32'h2000);
    branch_target = 32'h2002;
    cyc(3);
    chk("mis_halted", {31'd0, halted}, 32'd1);
    chk("mis_err", {31'd0, error}, 32'd1);
    chk("mis_pc", pc, 32'h2000);
    chk("mis_retired", retired, 32'd1);

    // halt+illegal together, then halt alone
    go_reset();
    dec_halt = 1'b1; dec_illegal = 1'b1;
    do_start();
    cyc(2);
    chk("both_err", {31'd0, error}, 32'd1);
    go_reset();
    dec_halt = 1'b1;
    do_start();
    cyc(2);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_err", {31'd0, error}, 32'd0);
    start = 1'b1;
    cyc(3);
    start = 1'b0;
    chk("halt_ignores_start", {31'd0, halted}, 32'd1);
    chk("halt_retired", retired, 32'd0);

    // pc wrap from 0xFFFFFFFC
    go_reset();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    do_start();
    cyc(4);
    chk("wrap_pre", pc, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    cyc(4);
    chk("wrap_pc", pc, 32'h0000_0000);
    chk("wrap_retired", retired, 32'd2);

    // Asynchronous reset in EXECUTE
    go_reset();
    do_start();
    cyc(2);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_wr", {31'd0, register_write_en}, 32'd0);
    chk("arst_pc", pc, 32'h1000);
    chk("arst_retired", retired, 32'd0);
    cyc(1);
    reset = 1'b1;
    cyc(3);
    chk("post_rst_idle", {31'd0, imem_req}, 32'd0);
    chk("post_rst_retired", retired, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 SHALL have parameter ADDRESS_SIZE, default 32, the width of the PC, the fetch address and the instruction register.
REQ-002 SHALL have parameter BOOT_ADDRESS, default 32'h1000, the PC value after reset.
REQ-003 SHALL have parameter FETCH_TIMEOUT, default 16, the maximum number of FETCH cycles spent waiting for imem_ready.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, a level input that moves the block from IDLE to FETCH.
REQ-007 SHALL have port imem_req, output, 1, the fetch request.
REQ-008 SHALL have port imem_ready, input, 1, instruction memory's acknowledge; imem_instruction is valid when it is high.
REQ-009 SHALL have port imem_instruction, input, ADDRESS_SIZE, the fetched instruction word.
REQ-010 SHALL have port pc, output, ADDRESS_SIZE, the current fetch address.
REQ-011 SHALL have port ir, output, ADDRESS_SIZE, the latched instruction that feeds the decoder.
REQ-012 SHALL have port dec_halt, input, 1, the decoder's halt-opcode flag.
REQ-013 SHALL have port dec_illegal, input, 1, the decoder's illegal-opcode flag.
REQ-014 SHALL have port dec_register_write, input, 1, the decoder's write intent.
REQ-015 SHALL have port branch_taken, input, 1, sampled in EXECUTE.
REQ-016 SHALL have port branch_target, input, ADDRESS_SIZE, sampled in EXECUTE.
REQ-017 SHALL have port register_write_en, output, 1, the gated register-bank write strobe.
REQ-018 SHALL have ports busy, halted and error, output, 1 each, as status flags.
REQ-019 SHALL have port retired, output, 32, the count of retired instructions.

Function
REQ-020 SHALL implement a one-hot or encoded FSM with the states IDLE, FETCH, DECODE, EXECUTE, WRITEBACK and HALT.
REQ-021 IDLE SHALL go to FETCH on the cycle after start=1; otherwise it SHALL stay in IDLE.
REQ-022 FETCH SHALL drive imem_req=1 continuously; on imem_ready=1 it SHALL load ir from imem_instruction and go to DECODE, with imem_req low from the next cycle.
REQ-023 FETCH SHALL count its wait cycles; if FETCH_TIMEOUT cycles pass without imem_ready, it SHALL go to HALT with error=1.
REQ-024 DECODE SHALL last one cycle: if dec_illegal=1 it goes to HALT with error=1; else if dec_halt=1 it goes to HALT with error=0; else it goes to EXECUTE.
REQ-025 If dec_illegal and dec_halt are both 1 in DECODE, dec_illegal SHALL take priority.
REQ-026 EXECUTE SHALL last one cycle and register branch_taken and branch_target internally.
REQ-027 If the registered branch is taken and branch_target[1:0]!=0, the block SHALL go to HALT with error=1; pc and retired SHALL be unchanged and no write strobe SHALL occur.
REQ-028 WRITEBACK SHALL last one cycle and drive register_write_en=dec_register_write for that cycle only.
REQ-029 WRITEBACK SHALL update pc to the target if the branch was taken, else to pc+4 modulo 2^ADDRESS_SIZE (all ones minus 3 wraps to 0).
REQ-030 WRITEBACK SHALL increment retired, wrapping from 2^32-1 to 0, and then go to FETCH.
REQ-031 register_write_en SHALL be 0 in every state other than WRITEBACK.
REQ-032 Minimum latency SHALL be 4 cycles per instruction (FETCH, DECODE, EXECUTE, WRITEBACK) with imem_ready=1 on FETCH entry.
REQ-033 busy SHALL be 1 in FETCH, DECODE, EXECUTE and WRITEBACK, and 0 in IDLE and HALT.
REQ-034 halted SHALL be 1 only in HALT.
REQ-035 HALT SHALL be exited only by reset; start SHALL be ignored in HALT.
REQ-036 ir and pc SHALL stay stable in every state except their defined load points.

Reset
REQ-037 reset=0 SHALL immediately force: state=IDLE, pc=BOOT_ADDRESS, ir=0, retired=0, timeout counter=0, and imem_req=register_write_en=busy=halted=error=0.
REQ-038 Reset asserted mid-instruction SHALL abort that instruction with no write strobe and no retired increment.
REQ-039 After reset is released, the block SHALL wait for start before fetching.

Verification
REQ-040 Reset then start, imem_ready=1, three non-branch instructions -> pc 0x1000 to 0x100C, retired=3, register_write_en pulses in cycles 4, 8 and 12.
REQ-041 imem_ready held low for FETCH_TIMEOUT=16 cycles -> HALT, error=1, halted=1, imem_req=0.
REQ-042 branch_taken=1 with target 0x2000 -> next pc=0x2000; with target 0x2002 -> HALT with error=1 and pc unchanged.
REQ-043 dec_halt=1 and dec_illegal=1 together -> error=1; dec_halt=1 alone -> error=0, retired unchanged, then start is ignored.
REQ-044 pc preset near 0xFFFFFFFC by a branch, then a sequential instruction -> pc wraps to 0x00000000.
REQ-045 reset pulsed low during EXECUTE -> outputs return to reset values asynchronously and retired=0.
